// File: rtl/coin_pkg.sv
// Shared constants for the coin acceptor front end: credit width,
// default threshold/saturation and the credit value of each coin type.
package coin_pkg;

    localparam int CREDIT_W       = 4;
    localparam int SEG_W          = 7;
    localparam int DEF_THRESHOLD  = 10;
    localparam int DEF_MAX_CREDIT = 15;
    localparam int COIN_100_VAL   = 1;
    localparam int COIN_500_VAL   = 5;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex digit to active-low seven-segment decoder.
// Output bit 0 drives segment a, bit 6 drives segment g.
module hex_to_seg7
    import coin_pkg::*;
(
    input  logic [CREDIT_W-1:0] i_hex,
    output logic [SEG_W-1:0]    o_seg
);

    // Patterns are written g..a, a zero lights the segment
    always_comb begin
        o_seg = 7'b1111111;
        case (i_hex)
            4'h0: o_seg = 7'b1000000;
            4'h1: o_seg = 7'b1111001;
            4'h2: o_seg = 7'b0100100;
            4'h3: o_seg = 7'b0110000;
            4'h4: o_seg = 7'b0011001;
            4'h5: o_seg = 7'b0010010;
            4'h6: o_seg = 7'b0000010;
            4'h7: o_seg = 7'b1111000;
            4'h8: o_seg = 7'b0000000;
            4'h9: o_seg = 7'b0010000;
            4'hA: o_seg = 7'b0001000;
            4'hB: o_seg = 7'b0000011;
            4'hC: o_seg = 7'b1000110;
            4'hD: o_seg = 7'b0100001;
            4'hE: o_seg = 7'b0000110;
            4'hF: o_seg = 7'b0001110;
            default: o_seg = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/coin_front_end.sv
// Coin acceptor front end: synchronizes both coin sensors, counts rising
// edges into a saturating credit register and drives full flag and display.
module coin_front_end
    import coin_pkg::*;
#(
    parameter int THRESHOLD  = DEF_THRESHOLD,
    parameter int MAX_CREDIT = DEF_MAX_CREDIT
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                coin_100,
    input  logic                coin_500,
    input  logic                clear,
    output logic [CREDIT_W-1:0] total_coins,
    output logic                coins_full,
    output logic [SEG_W-1:0]    total_coins_display
);

    localparam int SUM_W = CREDIT_W + 1;
    localparam logic [SUM_W-1:0]    MAX_C    = SUM_W'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] THRESH_C = CREDIT_W'(THRESHOLD);

    // Bit 0 is the 100 sensor, bit 1 the 500 sensor
    logic [1:0]          r_meta;
    logic [1:0]          r_sync;
    logic [1:0]          r_prev;
    logic [1:0]          w_edge;
    logic [SUM_W-1:0]    w_add;
    logic [SUM_W-1:0]    w_sum;
    logic [CREDIT_W-1:0] r_total;

    // Flops reset to 1 so a sensor already high at release looks "old"
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_meta <= '1;
            r_sync <= '1;
            r_prev <= '1;
        end else begin
            r_meta <= {coin_500, coin_100};
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign w_edge = r_sync & ~r_prev;

    // Sum is one bit wider than the credit so overflow is visible before saturating
    always_comb begin
        w_add = '0;
        if (w_edge[0]) w_add = w_add + SUM_W'(COIN_100_VAL);
        if (w_edge[1]) w_add = w_add + SUM_W'(COIN_500_VAL);
        w_sum = {1'b0, r_total} + w_add;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_total <= '0;
        end else if (clear) begin
            r_total <= '0;
        end else if (w_sum > MAX_C) begin
            r_total <= MAX_C[CREDIT_W-1:0];
        end else begin
            r_total <= w_sum[CREDIT_W-1:0];
        end
    end

    assign total_coins = r_total;
    assign coins_full  = (r_total >= THRESH_C);

    hex_to_seg7 u_seg (
        .i_hex (r_total),
        .o_seg (total_coins_display)
    );

endmodule

// File: tb/tb_coin_front_end.sv
// Scoreboard bench for coin_front_end: stimulus pushes predicted outputs,
// a monitor pops one prediction per clock and compares against the DUT.
module tb_coin_front_end;

    typedef struct {
        int total;
        int full;
        int seg;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       coin_100 = 1'b1;
    logic       coin_500 = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] total_coins;
    logic       coins_full;
    logic [6:0] total_coins_display;

    int   errors = 0;
    int   checks = 0;
    exp_t expQ[$];

    // Reference model state: sampled sensor history since reset and credit
    int   hist100[$];
    int   hist500[$];
    int   mTotal;

    logic [6:0] segTab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    coin_front_end dut (
        .clock               (clock),
        .reset               (reset),
        .coin_100            (coin_100),
        .coin_500            (coin_500),
        .clear               (clear),
        .total_coins         (total_coins),
        .coins_full          (coins_full),
        .total_coins_display (total_coins_display)
    );

    always #5 clock = ~clock;

    task automatic compare(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("[TB] FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, req);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        compare("total_coins", int'(total_coins), e.total);
        compare("coins_full", int'(coins_full), e.full);
        compare("display", int'(total_coins_display), e.seg);
    endtask

    function automatic exp_t makeExp(input int t);
        exp_t e;
        e.total = t;
        e.full  = (t >= 10) ? 1 : 0;
        e.seg   = int'(segTab[t]);
        return e;
    endfunction

    // A coin counts when it was sampled high two edges ago after being low
    // three edges ago; clear sampled on the same edge wins.
    task automatic modelStep(input int c100, input int c500, input int clr);
        int n;
        int e100;
        int e500;
        hist100.push_back(c100);
        hist500.push_back(c500);
        n = hist100.size();
        e100 = (hist100[n-3] == 1 && hist100[n-4] == 0) ? 1 : 0;
        e500 = (hist500[n-3] == 1 && hist500[n-4] == 0) ? 1 : 0;
        if (clr != 0) begin
            mTotal = 0;
        end else begin
            mTotal = mTotal + e100 * 1 + e500 * 5;
            if (mTotal > 15) mTotal = 15;
        end
        if (hist100.size() > 8) begin
            void'(hist100.pop_front());
            void'(hist500.pop_front());
        end
        expQ.push_back(makeExp(mTotal));
    endtask

    task automatic modelReset();
        hist100 = '{1, 1, 1};
        hist500 = '{1, 1, 1};
        mTotal  = 0;
    endtask

    task automatic applyStimulus(input logic c100, input logic c500, input logic clr);
        @(negedge clock);
        coin_100 = c100;
        coin_500 = c500;
        clear    = clr;
        modelStep(int'(c100), int'(c500), int'(clr));
    endtask

    task automatic applyReset(input int cycles, input logic c100, input logic c500);
        @(negedge clock);
        reset    = 1'b1;
        coin_100 = c100;
        coin_500 = c500;
        clear    = 1'b0;
        #1;
        compare("async_reset_total", int'(total_coins), 0);
        compare("async_reset_full", int'(coins_full), 0);
        compare("async_reset_display", int'(total_coins_display), 7'b1000000);
        expQ.push_back(makeExp(0));
        for (int i = 1; i < cycles; i++) begin
            @(negedge clock);
            expQ.push_back(makeExp(0));
        end
        @(negedge clock);
        reset = 1'b0;
        modelReset();
        modelStep(int'(coin_100), int'(coin_500), int'(clear));
    endtask

    task automatic pulse(input logic c100, input logic c500, input int hi, input int lo);
        repeat (hi) applyStimulus(c100, c500, 1'b0);
        repeat (lo) applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: one prediction per clock, sampled just after the rising edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #2;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin
        int lvl100;
        int lvl500;
        int cnt100;
        int cnt500;
        modelReset();

        // Sensor held high through reset and beyond is never counted
        applyReset(5, 1'b1, 1'b0);
        repeat (10) applyStimulus(1'b1, 1'b0, 1'b0);
        compare("held_high_total", int'(total_coins), 0);
        compare("held_high_display", int'(total_coins_display), 7'b1000000);

        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (3) pulse(1'b1, 1'b0, 3, 3);
        compare("three_coins_total", int'(total_coins), 3);
        compare("three_coins_display", int'(total_coins_display), 7'b0110000);

        repeat (7) pulse(1'b1, 1'b0, 3, 3);
        compare("ten_coins_total", int'(total_coins), 10);
        compare("ten_coins_full", int'(coins_full), 1);
        compare("ten_coins_display", int'(total_coins_display), 7'b0001000);

        repeat (2) pulse(1'b1, 1'b0, 3, 3);
        pulse(1'b0, 1'b1, 3, 3);
        compare("saturate_total", int'(total_coins), 15);
        compare("saturate_display", int'(total_coins_display), 7'b0001110);

        applyReset(3, 1'b0, 1'b0);
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0);
        pulse(1'b1, 1'b1, 3, 3);
        compare("simultaneous_total", int'(total_coins), 6);

        pulse(1'b1, 1'b0, 3, 3);
        compare("before_clear_total", int'(total_coins), 7);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1);
        repeat (4) applyStimulus(1'b0, 1'b0, 1'b0);
        compare("clear_priority_total", int'(total_coins), 0);
        compare("clear_priority_full", int'(coins_full), 0);

        // Reset while a 500 coin is still inside the synchronizer
        pulse(1'b1, 1'b0, 3, 3);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyReset(2, 1'b0, 1'b0);
        repeat (5) applyStimulus(1'b0, 1'b0, 1'b0);
        compare("reset_in_flight_total", int'(total_coins), 0);

        // Random pulse trains respecting the 2-clock minimum high/low time
        lvl100 = 0;
        lvl500 = 0;
        cnt100 = 2;
        cnt500 = 3;
        for (int i = 0; i < 400; i++) begin
            if (cnt100 == 0) begin
                lvl100 = 1 - lvl100;
                cnt100 = int'($urandom_range(2, 5));
            end
            if (cnt500 == 0) begin
                lvl500 = 1 - lvl500;
                cnt500 = int'($urandom_range(2, 7));
            end
            applyStimulus(lvl100[0], lvl500[0], ($urandom_range(0, 24) == 0));
            cnt100--;
            cnt500--;
        end
        repeat (4) applyStimulus(1'b0, 1'b0, 1'b0);

        @(posedge clock);
        #3;
        compare("scoreboard_drained", expQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
